// File: rtl/dht11_fnd_display.sv
// dht11_fnd_display: turns the dht11 humidity/temperature bytes into two BCD digits each,
// using sequential double-dabble, and scans them onto a 4-digit common-anode 7-segment
// display as HH.TT.
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   humidity     binary humidity byte (%RH)
//   temperature  binary temperature byte (degC)
//   seg_7        segments {dp,g,f,e,d,c,b,a}, active-low
//   com          digit enables, active-low, com[3] leftmost
//   over_range   either displayed value was clamped to 99
//   busy         conversion in flight
module dht11_fnd_display #(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  output logic [7:0] seg_7,
  output logic [3:0] com,
  output logic       over_range,
  output logic       busy
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e         state_q, state_d;
  logic [15:0]    last_raw_q, last_raw_d;
  logic [7:0]     bin_h_q, bin_h_d, bin_t_q, bin_t_d;
  logic [9:0]     bcd_h_q, bcd_h_d, bcd_t_q, bcd_t_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           busy_q, busy_d;
  logic           over_q, over_d;
  // {hum tens, hum ones, tmp tens, tmp ones}; nibble i is scan index i
  logic [15:0]    digits_q, digits_d;
  logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]     idx_q, idx_d, idx_next;
  logic [7:0]     seg_q, seg_d;
  logic [3:0]     com_q, com_d;
  logic           tick;

  // One double-dabble step: correct nibbles >=5, then shift {bcd,bin} left.
  function automatic logic [17:0] dd_step(input logic [9:0] bcd, input logic [7:0] bin);
    logic [9:0] adj;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return {adj[8:0], bin, 1'b0};
  endfunction

  function automatic logic [7:0] clamp_digits(input logic [9:0] bcd);
    return (bcd[9:8] != 2'd0) ? 8'h99 : bcd[7:0];
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Conversion FSM
  always_comb begin
    state_d    = state_q;
    last_raw_d = last_raw_q;
    bin_h_d    = bin_h_q;
    bin_t_d    = bin_t_q;
    bcd_h_d    = bcd_h_q;
    bcd_t_d    = bcd_t_q;
    bit_cnt_d  = bit_cnt_q;
    busy_d     = busy_q;
    over_d     = over_q;
    digits_d   = digits_q;
    unique case (state_q)
      StIdle: begin
        if ({humidity, temperature} != last_raw_q) begin
          last_raw_d = {humidity, temperature};
          bin_h_d    = humidity;
          bin_t_d    = temperature;
          bcd_h_d    = '0;
          bcd_t_d    = '0;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          state_d    = StConv;
        end
      end
      StConv: begin
        {bcd_h_d, bin_h_d} = dd_step(bcd_h_q, bin_h_q);
        {bcd_t_d, bin_t_d} = dd_step(bcd_t_q, bin_t_q);
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        // All four digits land on the same edge so the scan never sees a mixed pair.
        digits_d = {clamp_digits(bcd_h_q), clamp_digits(bcd_t_q)};
        over_d   = (bcd_h_q[9:8] != 2'd0) || (bcd_t_q[9:8] != 2'd0);
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Display scanner, free-running and independent of the FSM
  assign tick     = (scan_cnt_q == CntW'(SCAN_DIV - 1));
  assign idx_next = idx_q + 2'd1;

  always_comb begin
    scan_cnt_d = tick ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    seg_d      = seg_q;
    com_d      = com_q;
    if (tick) begin
      idx_d = idx_next;
      com_d = ~(4'b0001 << idx_next);
      seg_d = seg_code(digits_q[{idx_next, 2'b00} +: 4]);
      if (idx_next == 2'd2) seg_d[7] = 1'b0;  // decimal point after humidity
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      last_raw_q <= 16'h0000;
      bin_h_q    <= '0;
      bin_t_q    <= '0;
      bcd_h_q    <= '0;
      bcd_t_q    <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      over_q     <= 1'b0;
      digits_q   <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= 8'hFF;
      com_q      <= 4'b1111;
    end else begin
      state_q    <= state_d;
      last_raw_q <= last_raw_d;
      bin_h_q    <= bin_h_d;
      bin_t_q    <= bin_t_d;
      bcd_h_q    <= bcd_h_d;
      bcd_t_q    <= bcd_t_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= busy_d;
      over_q     <= over_d;
      digits_q   <= digits_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      com_q      <= com_d;
    end
  end

  assign seg_7      = seg_q;
  assign com        = com_q;
  assign over_range = over_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dht11_fnd_display.sv
// Scoreboard bench for dht11_fnd_display: the stimulus pushes the expected display
// contents for every value change; a monitor pops them when busy falls and checks
// the scanned segments, com pattern, over_range and conversion length every cycle.
module tb_dht11_fnd_display;

  localparam int unsigned ScanDiv = 4;
  localparam logic [7:0] CodeTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk;
  logic       reset_n;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic [7:0] seg_7;
  logic [3:0] com;
  logic       over_range;
  logic       busy;

  dht11_fnd_display #(.SCAN_DIV(ScanDiv)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .humidity    (humidity),
    .temperature (temperature),
    .seg_7       (seg_7),
    .com         (com),
    .over_range  (over_range),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // {over, hum tens, hum ones, tmp tens, tmp ones}
  logic [16:0] exp_q[$];
  logic [15:0] model_last;
  int          busy_rises = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Reference: decimal digits of each value, 99 when above 99.
  function automatic logic [16:0] model(input int h, input int t);
    int hh;
    int tt;
    hh = (h > 99) ? 99 : h;
    tt = (t > 99) ? 99 : t;
    return {(h > 99) || (t > 99), 4'(hh / 10), 4'(hh % 10), 4'(tt / 10), 4'(tt % 10)};
  endfunction

  // Clock edges seen since reset release; the scan ticks every ScanDiv of them.
  int n;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) n <= 0;
    else n <= n + 1;
  end

  // Monitor
  logic [15:0] disp_exp;
  logic        over_exp;
  logic [7:0]  seg_exp;
  logic [3:0]  com_exp;
  logic        prev_busy;
  int          hi_cnt;
  int          idx;
  logic [16:0] e;

  always @(negedge clk) begin
    if (!reset_n) begin
      disp_exp  = '0;
      over_exp  = 1'b0;
      seg_exp   = 8'hFF;
      com_exp   = 4'hF;
      prev_busy = 1'b0;
      hi_cnt    = 0;
      check("reset_seg", {24'd0, seg_7}, {24'd0, 8'hFF});
      check("reset_com", {28'd0, com}, {28'd0, 4'hF});
      check("reset_busy", {31'd0, busy}, 32'd0);
    end else begin
      if (n > 0 && (n % ScanDiv) == 0) begin
        idx     = (n / ScanDiv) % 4;
        com_exp = ~(4'b0001 << idx);
        seg_exp = CodeTab[disp_exp[idx*4 +: 4]];
        if (idx == 2) seg_exp[7] = 1'b0;
      end
      if (busy && !prev_busy) begin
        busy_rises++;
        hi_cnt = 0;
        check("busy_rise_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      end
      if (busy) hi_cnt++;
      if (!busy && prev_busy) begin
        check("busy_len", hi_cnt, 9);
        if (exp_q.size() > 0) begin
          e        = exp_q.pop_front();
          disp_exp = e[15:0];
          over_exp = e[16];
        end else begin
          check("result_expected", 32'd0, 32'd1);
        end
      end
      prev_busy = busy;
      check("seg", {24'd0, seg_7}, {24'd0, seg_exp});
      check("com", {28'd0, com}, {28'd0, com_exp});
      check("over_range", {31'd0, over_range}, {31'd0, over_exp});
    end
  end

  task automatic apply(input int h, input int t);
    @(posedge clk);
    #2;
    humidity    = 8'(h);
    temperature = 8'(t);
    if ({humidity, temperature} != model_last) exp_q.push_back(model(h, t));
    model_last = {humidity, temperature};
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("idle_timeout", {31'd0, k < 200}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int r0;
  int h;
  int t;

  initial begin
    reset_n     = 1'b0;
    humidity    = 8'd0;
    temperature = 8'd0;
    model_last  = 16'h0000;
    repeat (3) @(posedge clk);
    #2;
    check("rst_over", {31'd0, over_range}, 32'd0);
    reset_n = 1'b1;

    // Zero inputs never start a conversion
    r0 = busy_rises;
    repeat (100) @(posedge clk);
    #2;
    check("zero_no_busy", busy_rises, r0);

    // Basic conversion, then scan through several full rotations
    apply(80, 25);
    wait_idle();
    repeat (40) @(posedge clk);

    // Reset in the middle of a conversion
    apply(12, 34);
    wait_idle();
    apply(80, 25);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    model_last = 16'h0000;
    #1;
    check("midconv_seg", {24'd0, seg_7}, {24'd0, 8'hFF});
    check("midconv_com", {28'd0, com}, {28'd0, 4'hF});
    check("midconv_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    exp_q.push_back(model(80, 25));
    model_last = {8'd80, 8'd25};
    reset_n = 1'b1;
    wait_idle();
    repeat (20) @(posedge clk);

    // Clamping
    apply(99, 150);
    wait_idle();
    check("clamp_over", {31'd0, over_range}, 32'd1);
    repeat (20) @(posedge clk);
    apply(99, 20);
    wait_idle();
    check("unclamp_over", {31'd0, over_range}, 32'd0);
    repeat (20) @(posedge clk);

    // Input change after the third CONV edge
    apply(40, 20);
    repeat (3) @(posedge clk);
    apply(41, 20);
    wait_idle();
    repeat (20) @(posedge clk);

    // Randomised values, with repeats and out-of-range values mixed in
    h = 0;
    t = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        h = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 99));
        t = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 99));
      end
      apply(h, t);
      wait_idle();
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end

    wait_idle();
    repeat (24) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
